// File: rtl/div_unit.sv
// Multi-cycle 32-bit restoring divider, signed or unsigned, fixed 33-edge latency.
// One restoring step per cycle, then a sign-fix cycle that registers q/r and pulses done.
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] q,
    output logic [31:0] r
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [4:0]  count;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs_mag;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;

    logic        dvd_neg;
    logic        dvs_neg;
    logic [31:0] dvd_abs;
    logic [31:0] dvs_abs;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    // Operand magnitudes; 0x80000000 maps to the unsigned value 2^31 unchanged.
    always_comb begin
        dvd_neg = is_signed & dividend[31];
        dvs_neg = is_signed & divisor[31];
        dvd_abs = dvd_neg ? (32'd0 - dividend) : dividend;
        dvs_abs = dvs_neg ? (32'd0 - divisor) : divisor;
    end

    // The partial remainder never reaches the divisor magnitude, so it fits in
    // 32 bits; only the shifted value needs the 33rd bit for the compare.
    always_comb begin
        shifted = {rem, quo[31]};
        trial   = shifted - {1'b0, dvs_mag};
    end

    // A zero divisor leaves rem = |dividend| and an all-ones quotient magnitude;
    // forcing q keeps the result sign-independent, and r = -|a| = a when negative.
    always_comb begin
        q_fix = div_zero ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - quo) : quo);
        r_fix = neg_r ? (32'd0 - rem) : rem;
    end

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (count == 5'd31) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, matching the hardware.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs_mag  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            q        <= '0;
            r        <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        count    <= '0;
                        rem      <= '0;
                        quo      <= dvd_abs;
                        dvs_mag  <= dvs_abs;
                        neg_q    <= dvd_neg ^ dvs_neg;
                        neg_r    <= dvd_neg;
                        div_zero <= (divisor == 32'd0);
                    end
                end
                RUN: begin
                    count <= count + 5'd1;
                    if (!trial[32]) begin
                        rem <= trial[31:0];
                        quo <= {quo[30:0], 1'b1};
                    end else begin
                        rem <= shifted[31:0];
                        quo <= {quo[30:0], 1'b0};
                    end
                end
                FIX: begin
                    q    <= q_fix;
                    r    <= r_fix;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: arithmetic reference model with per-cycle
// comparison, directed corner cases and randomized back-to-back operations.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] q;
    logic [31:0] r;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .q         (q),
        .r         (r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Results straight from the arithmetic definition of the division.
    function automatic void expected_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                         output logic [31:0] eq, output logic [31:0] er);
        int sa;
        int sb;
        if (b == 32'd0) begin
            eq = 32'hFFFF_FFFF;
            er = a;
        end else if (!s) begin
            eq = a / b;
            er = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            eq = 32'h8000_0000;
            er = 32'd0;
        end else begin
            sa = a;
            sb = b;
            eq = sa / sb;
            er = sa % sb;
        end
    endfunction

    // Transaction-level model: one op in flight, result due 33 edges after acceptance.
    int          cyc = 0;
    int          m_due = 0;
    bit          m_busy = 0;
    bit          m_done = 0;
    logic [31:0] m_q = '0;
    logic [31:0] m_r = '0;
    logic [31:0] pq;
    logic [31:0] pr;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0;
            m_done = 0;
            m_q    = '0;
            m_r    = '0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                if (cyc == m_due) begin
                    m_busy = 0;
                    m_done = 1;
                    m_q    = pq;
                    m_r    = pr;
                end
            end else if (start) begin
                m_busy = 1;
                m_due  = cyc + 33;
                expected_div(is_signed, dividend, divisor, pq, pr);
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc busy", {31'd0, busy}, {31'd0, m_busy});
            check("cyc done", {31'd0, done}, {31'd0, m_done});
            check("cyc q", q, m_q);
            check("cyc r", r, m_r);
        end
    end

    task automatic launch(input bit s, input logic [31:0] a, input logic [31:0] b);
        start     = 1'b1;
        is_signed = s;
        dividend  = a;
        divisor   = b;
    endtask

    // Waits for done (bounded), scrambling operands after the start edge and
    // optionally re-asserting start mid-run with different operands.
    task automatic wait_done(input string name, input logic [31:0] eq, input logic [31:0] er,
                             input int inject_at);
        int k = 0;
        int busy_n = 0;
        bit got = 0;
        while (k < 40 && !got) begin
            @(negedge clk);
            k++;
            if (busy) busy_n++;
            if (done) begin
                got = 1;
            end else begin
                if (k == 1) begin
                    start     = 1'b0;
                    dividend  = $urandom;
                    divisor   = $urandom;
                    is_signed = 1'($urandom);
                end
                if (inject_at != 0 && k == inject_at) launch(1'b1, 32'd12345, 32'd17);
                if (inject_at != 0 && k == inject_at + 1) start = 1'b0;
            end
        end
        start = 1'b0;
        check({name, " done seen"}, {31'd0, done}, 32'd1);
        check({name, " latency"}, k - 1, 32'd33);
        check({name, " busy cycles"}, busy_n, 32'd33);
        check({name, " q"}, q, eq);
        check({name, " r"}, r, er);
    endtask

    initial begin
        logic [31:0] eq;
        logic [31:0] er;
        logic [31:0] a;
        logic [31:0] b;
        bit          s;
        int          dn;

        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset q", q, 32'd0);
        check("reset r", r, 32'd0);
        chk_en = 1;
        reset  = 1'b0;

        // Pin the reference arithmetic with hand-computed values.
        expected_div(1'b1, 32'hFFFF_FFF9, 32'd2, eq, er);
        check("model -7/2 q", eq, 32'hFFFF_FFFD);
        check("model -7/2 r", er, 32'hFFFF_FFFF);
        expected_div(1'b1, 32'd7, 32'hFFFF_FFFE, eq, er);
        check("model 7/-2 q", eq, 32'hFFFF_FFFD);
        check("model 7/-2 r", er, 32'd1);

        @(negedge clk);
        launch(1'b0, 32'd100, 32'd7);
        wait_done("u 100/7", 32'd14, 32'd2, 0);
        @(negedge clk);
        launch(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done("s -7/2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        launch(1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_done("s 7/-2", 32'hFFFF_FFFD, 32'd1, 0);
        launch(1'b0, 32'd5, 32'd0);
        wait_done("u 5/0", 32'hFFFF_FFFF, 32'd5, 0);
        launch(1'b1, 32'd5, 32'd0);
        wait_done("s 5/0", 32'hFFFF_FFFF, 32'd5, 0);
        launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("s ovf", 32'h8000_0000, 32'd0, 0);
        launch(1'b0, 32'hFFFF_FFFF, 32'd1);
        wait_done("u max/1", 32'hFFFF_FFFF, 32'd0, 0);

        // Start during busy is ignored; the per-cycle compare catches a second done.
        @(negedge clk);
        launch(1'b0, 32'd1000, 32'd9);
        wait_done("start in busy", 32'd111, 32'd1, 11);

        // Back-to-back: start held in the done cycle.
        @(negedge clk);
        launch(1'b0, 32'd100, 32'd7);
        wait_done("b2b first", 32'd14, 32'd2, 0);
        check("done cycle busy", {31'd0, busy}, 32'd0);
        launch(1'b0, 32'd9, 32'd3);
        wait_done("b2b second", 32'd3, 32'd0, 0);

        // Reset mid-run aborts with no done pulse.
        @(negedge clk);
        launch(1'b0, 32'd1000, 32'd3);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort q", q, 32'd0);
        check("abort r", r, 32'd0);
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("abort no done", dn, 32'd0);
        launch(1'b0, 32'd20, 32'd6);
        wait_done("after abort 20/6", 32'd3, 32'd2, 0);

        // Randomized operations with corner-biased operands.
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 5))
                0:       a = 32'h8000_0000;
                1:       a = 32'hFFFF_FFFF;
                2:       a = 32'd0;
                3:       a = $urandom_range(0, 1000);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0:       b = 32'd0;
                1:       b = 32'd1;
                2:       b = 32'hFFFF_FFFF;
                3:       b = 32'h8000_0000;
                4:       b = $urandom_range(1, 50);
                default: b = $urandom;
            endcase
            s = 1'($urandom);
            expected_div(s, a, b, eq, er);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            launch(s, a, b);
            wait_done("random", eq, er, 0);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
